// File: rtl/id_inst_queue.sv
// id_inst_queue: in-order {pc, inst} FIFO between IF and ID with flush and optional empty-queue bypass.
module id_inst_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic empty, byp, push, pop, wr, rd;
  always_comb begin
    empty = count == '0;
    byp = BYPASS && empty && in_valid;
    in_ready = count != CW'(DEPTH);
    out_valid = !empty || byp;
    out_pc = !empty ? pc_mem[head] : byp ? in_pc : '0;
    out_inst = !empty ? inst_mem[head] : byp ? in_inst : '0;
    push = in_valid && in_ready && !flush;
    pop = out_valid && out_ready && !flush;
    // a bypassed item taken by ID in the same cycle never touches storage
    wr = push && !(byp && out_ready);
    rd = pop && !byp;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (wr) tail <= tail + 1'b1;
      if (rd) head <= head + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      pc_mem[tail] <= in_pc;
      inst_mem[tail] <= in_inst;
    end
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue: directed checks of the queue with and without bypass.
module tb_id_inst_queue;
  logic clk = 0, rst = 1;
  logic a_flush = 0, a_in_valid = 0, a_out_ready = 0, a_in_ready, a_out_valid;
  logic [31:0] a_in_pc = 0, a_in_inst = 0, a_out_pc, a_out_inst;
  logic [2:0] a_count;
  logic b_flush = 0, b_in_valid = 0, b_out_ready = 0, b_in_ready, b_out_valid;
  logic [31:0] b_in_pc = 0, b_in_inst = 0, b_out_pc, b_out_inst;
  logic [2:0] b_count;
  int errors = 0, checks = 0;
  logic [31:0] q_pc [$];
  always #5 clk = ~clk;
  id_inst_queue #(.DEPTH(4), .BYPASS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_pc(a_in_pc),
    .in_inst(a_in_inst), .in_ready(a_in_ready), .out_valid(a_out_valid), .out_pc(a_out_pc),
    .out_inst(a_out_inst), .out_ready(a_out_ready), .count(a_count));
  id_inst_queue #(.DEPTH(4), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_pc(b_in_pc),
    .in_inst(b_in_inst), .in_ready(b_in_ready), .out_valid(b_out_valid), .out_pc(b_out_pc),
    .out_inst(b_out_inst), .out_ready(b_out_ready), .count(b_count));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_a(input logic [31:0] pc, input logic [31:0] inst);
    a_in_valid = 1; a_in_pc = pc; a_in_inst = inst;
    step();
    a_in_valid = 0;
  endtask
  initial begin
    a_in_valid = 1; b_in_valid = 1;
    step(); step();
    chk("rst_count", a_count, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_pc", a_out_pc, 0);
    chk("rst_out_inst", a_out_inst, 0);
    chk("rst_b_count", b_count, 0);
    rst = 0; a_in_valid = 0; b_in_valid = 0;
    #1;
    // fill with ID stalled
    for (int i = 0; i < 4; i++) push_a(32'hBFC00000 + 4 * i, 32'h1000 + i);
    chk("fill_count", a_count, 4);
    chk("fill_in_ready", a_in_ready, 0);
    push_a(32'hBFC00010, 32'h2000);
    chk("full_drop_count", a_count, 4);
    chk("full_head_pc", a_out_pc, 32'hBFC00000);
    a_out_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", a_out_valid, 1);
      chk("drain_pc", a_out_pc, 32'hBFC00000 + 4 * i);
      chk("drain_inst", a_out_inst, 32'h1000 + i);
      step();
    end
    chk("drained_valid", a_out_valid, 0);
    chk("drained_count", a_count, 0);
    chk("drained_pc", a_out_pc, 0);
    // wrap-around with interleaved pops, reference queue as model
    for (int k = 0; k < 14; k++) begin
      a_in_valid = k < 10;
      a_in_pc = 32'h200 + 4 * k;
      a_in_inst = 32'h5000 + k;
      a_out_ready = !(k == 0 || k == 2 || k == 5);
      #1;
      if (q_pc.size() > 0) chk("wrap_head_pc", a_out_pc, q_pc[0]);
      chk("wrap_valid", a_out_valid, q_pc.size() > 0);
      if (a_out_ready && q_pc.size() > 0) void'(q_pc.pop_front());
      if (a_in_valid) q_pc.push_back(a_in_pc);
      step();
      chk("wrap_count", a_count, q_pc.size());
    end
    a_in_valid = 0; a_out_ready = 0;
    chk("wrap_empty", a_out_valid, 0);
    // stall hold
    push_a(32'h300, 32'h3C011234);
    for (int i = 0; i < 5; i++) begin
      chk("hold_inst", a_out_inst, 32'h3C011234);
      chk("hold_count", a_count, 1);
      step();
    end
    push_a(32'h304, 32'h24020001);
    chk("pair_count", a_count, 2);
    a_out_ready = 1;
    push_a(32'h308, 32'h24030002);
    a_out_ready = 0;
    chk("pushpop_count", a_count, 2);
    chk("pushpop_head", a_out_inst, 32'h24020001);
    push_a(32'h30C, 32'h24040003);
    chk("preflush_count", a_count, 3);
    a_flush = 1; a_out_ready = 1;
    push_a(32'h310, 32'hDEADBEEF);
    a_flush = 0; a_out_ready = 0;
    chk("flush_count", a_count, 0);
    chk("flush_valid", a_out_valid, 0);
    chk("flush_in_ready", a_in_ready, 1);
    push_a(32'h400, 32'h000000AA);
    chk("postflush_pc", a_out_pc, 32'h400);
    chk("postflush_count", a_count, 1);
    // bypass instance
    b_in_valid = 1; b_in_pc = 32'h100; b_in_inst = 32'h11; b_out_ready = 1;
    #1;
    chk("byp_valid", b_out_valid, 1);
    chk("byp_pc", b_out_pc, 32'h100);
    chk("byp_inst", b_out_inst, 32'h11);
    step();
    chk("byp_count", b_count, 0);
    b_out_ready = 0;
    #1;
    chk("byp_stall_pc", b_out_pc, 32'h100);
    step();
    b_in_valid = 0;
    #1;
    chk("byp_store_count", b_count, 1);
    chk("byp_store_pc", b_out_pc, 32'h100);
    chk("byp_store_valid", b_out_valid, 1);
    b_in_valid = 1; b_in_pc = 32'h104; b_in_inst = 32'h22;
    #1;
    chk("byp_nonempty_head", b_out_pc, 32'h100);
    b_flush = 1;
    step();
    b_flush = 0;
    #1;
    chk("byp_flush_count", b_count, 0);
    chk("byp_flush_valid", b_out_valid, 1);
    chk("byp_flush_pc", b_out_pc, 32'h104);
    b_in_valid = 0;
    #1;
    chk("byp_idle_valid", b_out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
